// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and its decode helpers.
// Contents: fetch FSM state encoding, NOP constant, instruction field bit positions.
// Combinational helpers only; no state lives here.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int OP_LSB = 0;
    localparam int OP_MSB = 6;
    localparam int F3_LSB = 12;
    localparam int F3_MSB = 14;
    localparam int F7_LSB = 25;
    localparam int F7_MSB = 31;

    // A redirect target is usable only if it is word aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return |addr_lsbs;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_field_split.sv
// Splits a 32-bit instruction word into opcode, funct3 and funct7 fields.
// Ports: instr (in, 32) -> Op (7), funct3 (3), funct7 (7).
// Purely combinational, zero latency, no flow control.
module instr_fetch_unit_field_split
    import instr_fetch_unit_pkg::*;
(
    input  logic [31:0] instr,
    output logic [6:0]  Op,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7
);

    assign Op     = instr[OP_MSB:OP_LSB];
    assign funct3 = instr[F3_MSB:F3_LSB];
    assign funct7 = instr[F7_MSB:F7_LSB];

    // Register/immediate fields are decoded elsewhere.
    logic unused_bits;
    assign unused_bits = ^{instr[24:15], instr[11:7]};

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time, holds it for decode.
// Ports: imem_req/addr/ready/rdata memory side; dec_valid/ready + fields + PCs toward decode;
//        PCSrc/pc_target/flush redirect inputs; misalign_err sticky fault flag.
// Latency: one FETCH cycle (with immediate imem_ready) plus one HOLD cycle per instruction;
//          waits in FETCH for imem_ready and in HOLD for dec_ready.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [6:0]        Op,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              PCSrc,
    input  logic [ADDR_W-1:0] pc_target,
    input  logic              flush,
    output logic              misalign_err
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              err_q, err_d;
    logic              redirect;

    // Natural wrap at 2^ADDR_W is intended.
    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        err_d    = err_q;
        redirect = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                // flush wins: any data arriving this cycle is dropped.
                if (flush) begin
                    redirect = 1'b1;
                end else if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    redirect = 1'b1;
                end else if (dec_ready) begin
                    if (PCSrc) begin
                        redirect = 1'b1;
                    end else begin
                        pc_d    = pc_plus4;
                        state_d = FETCH;
                    end
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase

        // A misaligned target parks the unit with PC untouched for debug.
        if (redirect) begin
            if (is_misaligned(pc_target[1:0])) begin
                state_d = ERR;
                err_d   = 1'b1;
            end else begin
                pc_d    = pc_target;
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    assign imem_req     = (state_q == FETCH);
    assign dec_valid    = (state_q == HOLD);
    assign imem_addr    = pc_q;
    assign pc_out       = pc_q;
    assign instr        = instr_q;
    assign misalign_err = err_q;

    // Fields come from the registered word, never straight from imem_rdata.
    instr_fetch_unit_field_split u_split (
        .instr  (instr_q),
        .Op     (Op),
        .funct3 (funct3),
        .funct7 (funct7)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios then randomized traffic,
// every cycle compared against a transaction-level reference model.
// A second instance with RESET_PC at the top of memory exercises PC wrap.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ready, dec_valid, dec_ready, PCSrc, flush, misalign_err;
    logic [31:0] imem_addr, imem_rdata, instr, pc_out, pc_plus4, pc_target;
    logic [6:0]  Op, funct7;
    logic [2:0]  funct3;

    logic        w_req, w_vld, w_err;
    logic [31:0] w_addr, w_instr, w_pc, w_p4;
    logic [6:0]  w_op, w_f7;
    logic [2:0]  w_f3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .Op(Op), .funct3(funct3), .funct7(funct7), .instr(instr),
        .pc_out(pc_out), .pc_plus4(pc_plus4),
        .PCSrc(PCSrc), .pc_target(pc_target), .flush(flush), .misalign_err(misalign_err)
    );

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1), .imem_rdata(32'h0000_0013),
        .dec_valid(w_vld), .dec_ready(1'b1),
        .Op(w_op), .funct3(w_f3), .funct7(w_f7), .instr(w_instr),
        .pc_out(w_pc), .pc_plus4(w_p4),
        .PCSrc(1'b0), .pc_target(32'h0), .flush(1'b0), .misalign_err(w_err)
    );

    // Reference model: what the unit is doing, in transaction terms.
    bit          m_in_idle;     // the single post-reset dead cycle
    bit          m_holding;     // an instruction is being offered to decode
    bit          m_faulted;     // stopped by a misaligned redirect
    logic [31:0] m_pc;
    logic [31:0] m_word;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_in_idle = 1'b1;
        m_holding = 1'b0;
        m_faulted = 1'b0;
        m_pc      = 32'h0;
        m_word    = 32'h0000_0013;
    endfunction

    function automatic void model_jump(input logic [31:0] tgt);
        m_holding = 1'b0;
        if (tgt % 4 != 0) m_faulted = 1'b1;
        else              m_pc      = tgt;
    endfunction

    // Applies the inputs the DUT sampled at this rising edge.
    function automatic void model_step();
        if (!rst) begin
            model_reset();
        end else if (m_in_idle) begin
            m_in_idle = 1'b0;
        end else if (m_faulted) begin
            // dead until reset
        end else if (!m_holding) begin
            if (flush) model_jump(pc_target);
            else if (imem_ready) begin
                m_word    = imem_rdata;
                m_holding = 1'b1;
            end
        end else begin
            if (flush) model_jump(pc_target);
            else if (dec_ready) begin
                if (PCSrc) model_jump(pc_target);
                else begin
                    m_holding = 1'b0;
                    m_pc      = m_pc + 32'd4;
                end
            end
        end
    endfunction

    task automatic compare_all();
        logic fetching;
        fetching = !m_in_idle && !m_faulted && !m_holding;
        chk("imem_req",  {31'b0, imem_req},     {31'b0, fetching});
        chk("dec_valid", {31'b0, dec_valid},    {31'b0, m_holding});
        chk("imem_addr", imem_addr,             m_pc);
        chk("pc_out",    pc_out,                m_pc);
        chk("pc_plus4",  pc_plus4,              m_pc + 32'd4);
        chk("instr",     instr,                 m_word);
        chk("Op",        {25'b0, Op},           {25'b0, m_word[6:0]});
        chk("funct3",    {29'b0, funct3},       {29'b0, m_word[14:12]});
        chk("funct7",    {25'b0, funct7},       {25'b0, m_word[31:25]});
        chk("misalign",  {31'b0, misalign_err}, {31'b0, m_faulted});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Leaves reset just released with the unit in its IDLE cycle.
    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic set_idle_inputs();
        imem_ready = 1'b0; dec_ready = 1'b0; PCSrc = 1'b0; flush = 1'b0;
        pc_target  = 32'h0; imem_rdata = 32'h0;
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1;
        set_idle_inputs();
        #2;
        do_reset();

        // Reset values, still in IDLE before the first clocked edge.
        chk("rst_req",  {31'b0, imem_req},  32'd0);
        chk("rst_vld",  {31'b0, dec_valid}, 32'd0);
        chk("rst_pc",   pc_out,             32'h0);
        chk("rst_p4",   pc_plus4,           32'h4);
        chk("rst_op",   {25'b0, Op},        32'h13);
        chk("rst_inst", instr,              32'h0000_0013);
        chk("rst_err",  {31'b0, misalign_err}, 32'd0);
        chk("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap_rst_p4",   w_p4,   32'h0);

        // Free-running sequential fetch, 2 cycles per instruction.
        imem_ready = 1'b1; dec_ready = 1'b1; imem_rdata = 32'h0050_0093;
        tick(); chk("seq_req0", {31'b0, imem_req}, 32'd1); chk("seq_addr0", imem_addr, 32'h0);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        tick(); chk("seq_vld0", {31'b0, dec_valid}, 32'd1); chk("seq_req_hold", {31'b0, imem_req}, 32'd0);
        tick(); chk("seq_addr1", imem_addr, 32'h4);
        chk("wrap_addr1", w_addr, 32'h0); chk("wrap_err", {31'b0, w_err}, 32'd0);
        tick();
        tick(); chk("seq_addr2", imem_addr, 32'h8);

        // Decode stall holds the instruction steady.
        do_reset();
        tick();
        dec_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_vld",  {31'b0, dec_valid}, 32'd1);
            chk("stall_req",  {31'b0, imem_req},  32'd0);
            chk("stall_op",   {25'b0, Op},        32'h13);
            chk("stall_f3",   {29'b0, funct3},    32'd0);
            chk("stall_pc",   pc_out,             32'h0);
            tick();
        end
        dec_ready = 1'b1;
        tick(); chk("stall_next_req", {31'b0, imem_req}, 32'd1); chk("stall_next_addr", imem_addr, 32'h4);

        // Taken branch, then memory stall on the target.
        tick(); tick(); tick();
        chk("br_from_pc", pc_out, 32'h8);
        PCSrc = 1'b1; pc_target = 32'h100; imem_ready = 1'b0;
        tick(); chk("br_addr", imem_addr, 32'h100);
        PCSrc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("memstall_addr", imem_addr, 32'h100);
            chk("memstall_req",  {31'b0, imem_req},  32'd1);
            chk("memstall_vld",  {31'b0, dec_valid}, 32'd0);
        end

        // Flush beats a simultaneous memory response.
        imem_ready = 1'b1; flush = 1'b1; pc_target = 32'h40;
        tick(); chk("flush_addr", imem_addr, 32'h40); chk("flush_vld", {31'b0, dec_valid}, 32'd0);
        flush = 1'b0; imem_ready = 1'b0;
        tick(); chk("flush_vld2", {31'b0, dec_valid}, 32'd0);

        // Misaligned branch target faults; flush is then ignored.
        imem_ready = 1'b1;
        tick();
        PCSrc = 1'b1; pc_target = 32'h102; dec_ready = 1'b1;
        tick();
        chk("mis_err", {31'b0, misalign_err}, 32'd1);
        chk("mis_req", {31'b0, imem_req},     32'd0);
        chk("mis_pc",  pc_out,                32'h40);
        PCSrc = 1'b0; flush = 1'b1; pc_target = 32'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err_req", {31'b0, imem_req},  32'd0);
            chk("err_vld", {31'b0, dec_valid}, 32'd0);
        end
        flush = 1'b0;

        // Reset pulse in the middle of a fetch.
        do_reset();
        tick();
        chk("midfetch_req", {31'b0, imem_req}, 32'd1);
        do_reset();
        chk("midrst_pc",  pc_out, 32'h0);
        chk("midrst_err", {31'b0, misalign_err}, 32'd0);
        chk("midrst_req", {31'b0, imem_req}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) begin
                set_idle_inputs();
                do_reset();
            end
            imem_ready = 1'($urandom_range(0, 1));
            dec_ready  = 1'($urandom_range(0, 1));
            PCSrc      = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 19);
            if (r == 0)      pc_target = $urandom | 32'h1;
            else if (r == 1) pc_target = 32'hFFFF_FFFC;
            else             pc_target = $urandom & 32'h0000_0FFC;
            imem_rdata = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
